// File: rtl/sprite_engine.sv
// sprite_engine: 16x16 sprite hit-test, two-frame animation and hit-blink for a picture ROM.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_en                pixel strobe gating the output registers
//   hcount, vcount        current pixel position; video_on marks the visible area
//   frame_tick            one-clk pulse at vblank start (latches position, steps animation/blink)
//   sprite_x, sprite_y    requested sprite top-left corner
//   base_index, anim_en   first picture and two-frame animation enable
//   hit                   starts or restarts an inversion blink
//   addr, romEN, index, inv   registered picture-ROM address, enable, picture select, invert
module sprite_engine #(
    parameter int ANIM_DIV     = 8,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    input  logic       frame_tick,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic [3:0] base_index,
    input  logic       anim_en,
    input  logic       hit,
    output logic [7:0] addr,
    output logic       romEN,
    output logic [3:0] index,
    output logic       inv
);
    typedef enum logic {IDLE, BLINK} state_t;

    state_t     state_q, state_d;
    logic [9:0] x_l_q, x_l_d, y_l_q, y_l_d;
    logic [7:0] anim_cnt_q, anim_cnt_d, blink_cnt_q, blink_cnt_d;
    logic       frame_sel_q, frame_sel_d;
    logic [7:0] addr_q, addr_d;
    logic       rom_en_q, rom_en_d, inv_q, inv_d;
    logic [3:0] index_q, index_d;
    logic [9:0] dx, dy;
    logic       vis, blink_inv;
    logic [3:0] pic;

    always_comb begin
        // Subtraction wraps modulo 1024, so a sprite near the right/bottom edge
        // still covers columns/rows just past zero.
        dx        = hcount - x_l_q;
        dy        = vcount - y_l_q;
        vis       = (dx < 10'd16) && (dy < 10'd16) && video_on;
        // Only even bases 0..8 have a second animation frame next to them.
        pic       = (base_index <= 4'd8 && !base_index[0]) ? base_index + {3'b000, frame_sel_q} : base_index;
        blink_inv = (state_q == BLINK) && blink_cnt_q[2];
        x_l_d       = frame_tick ? sprite_x : x_l_q;
        y_l_d       = frame_tick ? sprite_y : y_l_q;
        anim_cnt_d  = anim_cnt_q;
        frame_sel_d = frame_sel_q;
        if (!anim_en) begin
            anim_cnt_d  = 8'd0;
            frame_sel_d = 1'b0;
        end else if (frame_tick) begin
            anim_cnt_d  = (anim_cnt_q == 8'(ANIM_DIV - 1)) ? 8'd0 : anim_cnt_q + 8'd1;
            frame_sel_d = frame_sel_q ^ (anim_cnt_q == 8'(ANIM_DIV - 1));
        end
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        if (hit) begin
            // A hit always (re)starts the episode, even on the terminating tick.
            state_d     = BLINK;
            blink_cnt_d = 8'd0;
        end else if (state_q == BLINK && frame_tick) begin
            state_d     = (blink_cnt_q == 8'(BLINK_FRAMES - 1)) ? IDLE : BLINK;
            blink_cnt_d = (blink_cnt_q == 8'(BLINK_FRAMES - 1)) ? 8'd0 : blink_cnt_q + 8'd1;
        end
        rom_en_d = pix_en ? vis : rom_en_q;
        addr_d   = pix_en ? (vis ? {dy[3:0], dx[3:0]} : 8'h00) : addr_q;
        index_d  = pix_en ? pic : index_q;
        inv_d    = pix_en ? blink_inv : inv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_l_q       <= '0;
            y_l_q       <= '0;
            anim_cnt_q  <= '0;
            frame_sel_q <= 1'b0;
            blink_cnt_q <= '0;
            addr_q      <= '0;
            rom_en_q    <= 1'b0;
            index_q     <= '0;
            inv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_l_q       <= x_l_d;
            y_l_q       <= y_l_d;
            anim_cnt_q  <= anim_cnt_d;
            frame_sel_q <= frame_sel_d;
            blink_cnt_q <= blink_cnt_d;
            addr_q      <= addr_d;
            rom_en_q    <= rom_en_d;
            index_q     <= index_d;
            inv_q       <= inv_d;
        end
    end

    assign addr  = addr_q;
    assign romEN = rom_en_q;
    assign index = index_q;
    assign inv   = inv_q;
endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: directed-vector bench for sprite_engine with hand-computed expectations.
module tb_sprite_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       video_on = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] sprite_x = '0;
    logic [9:0] sprite_y = '0;
    logic [3:0] base_index = '0;
    logic       anim_en = 1'b0;
    logic       hit = 1'b0;
    logic [7:0] addr;
    logic       romEN;
    logic [3:0] index;
    logic       inv;
    int         n_chk = 0;
    int         n_fail = 0;

    sprite_engine #(.ANIM_DIV(8), .BLINK_FRAMES(32)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .base_index(base_index), .anim_en(anim_en), .hit(hit),
        .addr(addr), .romEN(romEN), .index(index), .inv(inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pos(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        step();
    endtask

    initial begin
        #2;
        check("rst_addr", addr, 0);
        check("rst_romen", romEN, 0);
        check("rst_index", index, 0);
        check("rst_inv", inv, 0);
        step();
        rst_n = 1'b1;
        pix_en = 1'b1;
        video_on = 1'b1;
        step();
        // sprite sits at origin until the first frame_tick
        pos(5, 3);
        check("origin_romen", romEN, 1);
        check("origin_addr", addr, 8'h35);
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        tick();
        pos(103, 57);
        check("in_romen", romEN, 1);
        check("in_addr", addr, 8'h73);
        pos(116, 57);
        check("right_romen", romEN, 0);
        check("right_addr", addr, 0);
        pos(99, 57);
        check("left_romen", romEN, 0);
        check("left_addr", addr, 0);
        pos(115, 65);
        check("corner_addr", addr, 8'hff);
        video_on = 1'b0;
        pos(103, 57);
        check("blank_romen", romEN, 0);
        check("blank_addr", addr, 0);
        video_on = 1'b1;
        pix_en = 1'b0;
        pos(103, 57);
        check("hold0_romen", romEN, 0);
        pix_en = 1'b1;
        pos(103, 57);
        check("resume_romen", romEN, 1);
        pix_en = 1'b0;
        pos(116, 57);
        check("hold1_romen", romEN, 1);
        check("hold1_addr", addr, 8'h73);
        pix_en = 1'b1;
        // position change without frame_tick has no effect
        sprite_x = 10'd200;
        pos(103, 57);
        check("midframe_romen", romEN, 1);
        tick();
        pos(203, 57);
        check("moved_romen", romEN, 1);
        check("moved_addr", addr, 8'h73);
        pos(103, 57);
        check("old_pos_romen", romEN, 0);
        // column wrap modulo 1024
        sprite_x = 10'd1020;
        tick();
        pos(3, 57);
        check("wrap_romen", romEN, 1);
        check("wrap_addr", addr, 8'h77);
        // animation
        base_index = 4'd4;
        anim_en = 1'b1;
        step();
        check("anim_t0", index, 4);
        for (int t = 1; t <= 16; t++) begin
            tick();
            step();
            if (t == 7 || t == 8 || t == 9 || t == 15 || t == 16)
                check($sformatf("anim_t%0d", t), index, (t >= 8 && t < 16) ? 4'd5 : 4'd4);
        end
        for (int t = 1; t <= 8; t++) tick();
        step();
        check("anim_sel1", index, 5);
        anim_en = 1'b0;
        step();
        step();
        check("anim_off", index, 4);
        base_index = 4'd10;
        anim_en = 1'b1;
        for (int t = 1; t <= 8; t++) tick();
        step();
        check("anim_odd_base", index, 10);
        anim_en = 1'b0;
        base_index = 4'd0;
        // blink episode
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
        check("blink_t0", inv, 0);
        for (int t = 1; t <= 32; t++) begin
            tick();
            step();
            if (t == 3 || t == 4 || t == 7 || t == 8 || t == 31 || t == 32)
                check($sformatf("blink_t%0d", t), inv, (t < 32) ? 32'((t >> 2) & 1) : 32'd0);
        end
        for (int t = 1; t <= 6; t++) tick();
        step();
        check("idle_stays", inv, 0);
        // restart on the terminating tick
        hit = 1'b1;
        step();
        hit = 1'b0;
        for (int t = 1; t <= 31; t++) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int t = 1; t <= 28; t++) tick();
        step();
        check("restart_28", inv, 1);
        for (int t = 1; t <= 3; t++) tick();
        step();
        check("restart_31", inv, 1);
        tick();
        step();
        check("restart_end", inv, 0);
        // asynchronous reset mid-blink with pix_en low
        sprite_x = 10'd100;
        tick();
        hit = 1'b1;
        step();
        hit = 1'b0;
        for (int t = 1; t <= 5; t++) tick();
        pos(103, 57);
        check("pre_rst_inv", inv, 1);
        check("pre_rst_romen", romEN, 1);
        pix_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", addr, 0);
        check("arst_romen", romEN, 0);
        check("arst_index", index, 0);
        check("arst_inv", inv, 0);
        step();
        rst_n = 1'b1;
        pix_en = 1'b1;
        pos(5, 3);
        check("post_rst_romen", romEN, 1);
        check("post_rst_addr", addr, 8'h35);
        check("post_rst_inv", inv, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter ANIM_DIV, default 8, frame_tick count between animation frame swaps (range 1..255).
REQ-002 Parameter BLINK_FRAMES, default 32, frame_tick count of one hit-blink episode (range 1..255).
REQ-003 clk  in  1  pixel-domain system clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pix_en  in  1  pixel strobe; all state except the FSM/counters advances only when high.
REQ-006 hcount  in  10  current pixel column.
REQ-007 vcount  in  10  current pixel row.
REQ-008 video_on  in  1  visible-area flag for hcount/vcount.
REQ-009 frame_tick  in  1  one-clk pulse at vblank start.
REQ-010 sprite_x  in  10  requested sprite left column.
REQ-011 sprite_y  in  10  requested sprite top row.
REQ-012 base_index  in  4  picture-ROM index of the sprite's first frame.
REQ-013 anim_en  in  1  enable two-frame animation.
REQ-014 hit  in  1  one-clk pulse starting an inversion blink.
REQ-015 addr  out  8  picture-ROM address, {row[3:0], col[3:0]}.
REQ-016 romEN  out  1  pixel lies inside sprite and visible area.
REQ-017 index  out  4  picture-ROM picture select.
REQ-018 inv  out  1  colour-invert request to picture ROM.

Function
REQ-019 sprite_x/sprite_y SHALL be captured into x_l/y_l only on frame_tick; mid-frame changes have no visible effect.
REQ-020 dx = hcount - x_l and dy = vcount - y_l, SHALL be 10-bit unsigned (modulo 1024); inside = (dx < 16) and (dy < 16).
REQ-021 On a clk with pix_en=1 SHALL register: romEN <= inside & video_on; addr <= {dy[3:0], dx[3:0]}; index <= current picture; inv <= blink_inv.
REQ-022 Outputs SHALL hold when pix_en=0; latency hcount/vcount to outputs is exactly one pix_en-qualified clk.
REQ-023 addr SHALL be 8'h00 whenever the registered romEN is 0.
REQ-024 Animation: when anim_en=1, anim_cnt (8 bits) SHALL increment on each frame_tick; at anim_cnt == ANIM_DIV-1 it wraps to 0 and frame_sel toggles.
REQ-025 When anim_en=0, anim_cnt and frame_sel SHALL clear to 0 on the next clk.
REQ-026 Current picture SHALL be base_index + frame_sel only if base_index is in {0,2,4,6,8}; otherwise base_index unchanged (frame_sel ignored).
REQ-027 Blink FSM states IDLE, BLINK; IDLE -> BLINK on hit, clearing blink_cnt to 0.
REQ-028 In BLINK, blink_cnt SHALL increment on each frame_tick; blink_inv = blink_cnt[2] (toggles every 4 frames, starts 0).
REQ-029 BLINK -> IDLE on the frame_tick at which blink_cnt == BLINK_FRAMES-1; blink_inv = 0 in IDLE.
REQ-030 hit in BLINK SHALL restart (blink_cnt <= 0, stay BLINK); hit coincident with the terminating frame_tick SHALL restart, not exit.
REQ-031 frame_tick and hit SHALL be acted on regardless of pix_en.

Reset
REQ-032 rst_n low SHALL asynchronously force addr=0, romEN=0, index=0, inv=0, x_l=0, y_l=0, anim_cnt=0, frame_sel=0, blink_cnt=0, FSM=IDLE.
REQ-033 Reset asserted mid-blink or mid-frame SHALL abort all activity; operation resumes from reset state on first clk after rst_n rises.
REQ-034 After reset, no sprite is visible at (0,0)…(15,15) until... no: x_l=y_l=0 places sprite at origin until first frame_tick.

Verification
REQ-035 sprite_x=100, sprite_y=50, frame_tick, then hcount=103, vcount=57, video_on=1, pix_en=1 -> next clk romEN=1, addr=8'h73.
REQ-036 Same position, hcount=116 or hcount=99 -> romEN=0, addr=0; hcount=103, video_on=0 -> romEN=0.
REQ-037 sprite_x changed to 200 mid-frame, no frame_tick -> hcount=103 still inside; after frame_tick hcount=203 inside, 103 outside.
REQ-038 base_index=4, anim_en=1, ANIM_DIV=8 -> index 4 for frame_ticks 0..7, 5 after 8th, 4 after 16th; base_index=10 -> index 10 always.
REQ-039 hit, BLINK_FRAMES=32 -> inv 0 for ticks 0-3, 1 for 4-7, ...; FSM IDLE and inv=0 after 32nd tick; second hit at tick 31 -> blink continues 32 more ticks.
REQ-040 rst_n pulsed low during BLINK with pix_en=0 -> outputs zero immediately, without a clk edge.
